// File: rtl/interrupt_responder.sv
// Single-level interrupt responder: edge detect, enable, vectoring and
// return sequencing with a saturating count of rejected interrupts.
module interrupt_responder #(
  parameter int              PC_W   = 10,
  parameter logic [PC_W-1:0] VECTOR = 10'h3FF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            intr_in,
  input  logic            int_set,
  input  logic            int_clr,
  input  logic            irq_ack,
  input  logic            reti,
  input  logic [PC_W-1:0] pc_in,
  input  logic [1:0]      flags_in,
  output logic            irq_req,
  output logic            vector_load,
  output logic [PC_W-1:0] vector_addr,
  output logic            ret_load,
  output logic [PC_W-1:0] pc_saved,
  output logic [1:0]      flags_saved,
  output logic            int_en,
  output logic            in_isr,
  output logic [7:0]      missed_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PEND,
    S_VEC,
    S_SERV,
    S_RET
  } state_t;

  state_t          state_q, state_d;
  logic            int_en_q, int_en_d;
  logic            prev_q, prev_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [1:0]      fl_q, fl_d;
  logic [7:0]      missed_q, missed_d;

  logic       edge_w;
  logic [1:0] miss_inc;
  logic [8:0] miss_sum;

  assign edge_w = intr_in & ~prev_q;

  always_comb begin
    state_d  = state_q;
    int_en_d = int_en_q;
    pc_d     = pc_q;
    fl_d     = fl_q;
    prev_d   = intr_in;
    miss_inc = 2'd0;
    // Any edge not accepted into PENDING is lost and counted.
    if (edge_w && !(state_q == S_IDLE && int_en_q))
      miss_inc = 2'd1;
    unique case (state_q)
      S_IDLE: begin
        if (edge_w && int_en_q)
          state_d = S_PEND;
        if (int_clr)
          int_en_d = 1'b0;
        else if (int_set)
          int_en_d = 1'b1;
      end
      S_PEND: begin
        if (irq_ack) begin
          pc_d     = pc_in;
          fl_d     = flags_in;
          int_en_d = 1'b0;
          state_d  = S_VEC;
        end else if (int_clr) begin
          int_en_d = 1'b0;
          state_d  = S_IDLE;
          miss_inc = miss_inc + 2'd1;
        end
      end
      S_VEC: state_d = S_SERV;
      S_SERV: begin
        int_en_d = 1'b0;
        if (reti)
          state_d = S_RET;
      end
      S_RET: begin
        int_en_d = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    miss_sum = {1'b0, missed_q} + {7'd0, miss_inc};
    missed_d = miss_sum[8] ? 8'hFF : miss_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      int_en_q <= 1'b0;
      prev_q   <= 1'b1;
      pc_q     <= '0;
      fl_q     <= 2'b00;
      missed_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      int_en_q <= int_en_d;
      prev_q   <= prev_d;
      pc_q     <= pc_d;
      fl_q     <= fl_d;
      missed_q <= missed_d;
    end
  end

  assign irq_req     = (state_q == S_PEND);
  assign vector_load = (state_q == S_VEC);
  assign ret_load    = (state_q == S_RET);
  assign in_isr      = (state_q == S_VEC) || (state_q == S_SERV);
  assign vector_addr = VECTOR;
  assign pc_saved    = pc_q;
  assign flags_saved = fl_q;
  assign int_en      = int_en_q;
  assign missed_cnt  = missed_q;

endmodule
